// File: rtl/node_interface_if.sv
// Bundles the core-side TX/RX streams and switch-side flit handshakes of one node.
// master = environment (core + switch) driving the node; slave = node_interface itself.
// Flit layout: {marker, dest[ADDR_SIZE-1:0], payload[DATA_SIZE-1:0]}.
interface node_interface_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4
);
    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;

    // core -> node word stream
    logic                 core_tx_valid;
    logic [ADDR_SIZE-1:0] core_tx_dest;
    logic [DATA_SIZE-1:0] core_tx_data;
    logic                 core_tx_ready;

    // node -> core word stream
    logic                 core_rx_valid;
    logic [DATA_SIZE-1:0] core_rx_data;
    logic                 core_rx_ready;

    // node -> switch flits
    logic                 sw_wr_ready_out;
    logic                 sw_r_ready_in;
    logic [BUS_SIZE-1:0]  sw_data_o;

    // switch -> node flits
    logic                 sw_wr_ready_in;
    logic                 sw_r_ready_out;
    logic [BUS_SIZE-1:0]  sw_data_i;

    modport master (
        output core_tx_valid, core_tx_dest, core_tx_data,
        input  core_tx_ready,
        input  core_rx_valid, core_rx_data,
        output core_rx_ready,
        input  sw_wr_ready_out, sw_data_o,
        output sw_r_ready_in,
        output sw_wr_ready_in, sw_data_i,
        input  sw_r_ready_out
    );

    modport slave (
        input  core_tx_valid, core_tx_dest, core_tx_data,
        output core_tx_ready,
        output core_rx_valid, core_rx_data,
        input  core_rx_ready,
        output sw_wr_ready_out, sw_data_o,
        input  sw_r_ready_in,
        input  sw_wr_ready_in, sw_data_i,
        output sw_r_ready_out
    );
endinterface

// File: rtl/node_interface.sv
// Generic 2-entry FIFO with registered full/empty (pointer + wrap-bit scheme).
// Latency: a word written at edge N is at the head after edge N.
// Backpressure: wr_rdy = !full from registered state; pop while full frees space next cycle.
module fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             wr_wrap_q, wr_wrap_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             rd_wrap_q, rd_wrap_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full   = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q != rd_wrap_q);
    assign empty  = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);
    assign wr_rdy = !full;
    assign rd_vld = !empty;
    assign rd_dat = mem_q[rd_ptr_q];
    assign push   = wr_vld && !full;
    assign pop    = rd_rdy && !empty;

    // Next-state: write at wr_ptr on push, advance {wrap,ptr} pairs so ptr wraps 1->0 and flips wrap.
    always_comb begin
        mem_d[0]  = mem_q[0];
        mem_d[1]  = mem_q[1];
        wr_ptr_d  = wr_ptr_q;
        wr_wrap_d = wr_wrap_q;
        rd_ptr_d  = rd_ptr_q;
        rd_wrap_d = rd_wrap_q;
        if (push) begin
            mem_d[wr_ptr_q]         = wr_dat;
            {wr_wrap_d, wr_ptr_d}   = {wr_wrap_q, wr_ptr_q} + 2'd1;
        end
        if (pop) begin
            {rd_wrap_d, rd_ptr_d}   = {rd_wrap_q, rd_ptr_q} + 2'd1;
        end
    end

    // State register; reset clears storage so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            wr_wrap_q <= 1'b0;
            rd_ptr_q  <= 1'b0;
            rd_wrap_q <= 1'b0;
        end else begin
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
            wr_ptr_q  <= wr_ptr_d;
            wr_wrap_q <= wr_wrap_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_wrap_q <= rd_wrap_d;
        end
    end
endmodule

// Local-port endpoint: core words -> switch flits, switch flits -> core words, with stats.
// Latency: 1 cycle core->sw_data_o and sw_data_i->core_rx_valid through 2-entry FIFOs.
// Backpressure: core_tx_ready/sw_r_ready_out = FIFO not full (registered); misrouted flits are consumed.
module node_interface #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int ADDR      = 0,
    parameter int CNT_SIZE  = 16
) (
    input  logic                clk,
    input  logic                a_rst,
    node_interface_if.slave     bus,
    output logic [CNT_SIZE-1:0] tx_count,
    output logic [CNT_SIZE-1:0] rx_count,
    output logic [CNT_SIZE-1:0] err_count
);
    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
    localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

    logic [BUS_SIZE-1:0]  tx_flit;
    logic                 tx_rd_vld;
    logic                 tx_fire;
    logic                 rx_marker;
    logic [ADDR_SIZE-1:0] rx_dest;
    logic                 rx_good;
    logic                 rx_wr_rdy;
    logic                 rx_accept;
    logic                 rx_push;
    logic                 rx_drop;
    logic [CNT_SIZE-1:0]  tx_count_q, tx_count_d;
    logic [CNT_SIZE-1:0]  rx_count_q, rx_count_d;
    logic [CNT_SIZE-1:0]  err_count_q, err_count_d;

    // TX: every accepted core word becomes a marked flit.
    assign tx_flit = {1'b1, bus.core_tx_dest, bus.core_tx_data};

    fifo2 #(.WIDTH(BUS_SIZE)) u_tx_fifo (
        .clk    (clk),
        .rst    (a_rst),
        .wr_vld (bus.core_tx_valid),
        .wr_rdy (bus.core_tx_ready),
        .wr_dat (tx_flit),
        .rd_vld (tx_rd_vld),
        .rd_rdy (bus.sw_r_ready_in),
        .rd_dat (bus.sw_data_o)
    );

    assign bus.sw_wr_ready_out = tx_rd_vld;
    assign tx_fire             = tx_rd_vld && bus.sw_r_ready_in;

    // RX: only marked flits addressed to this node are stored; the rest are still handshaken.
    assign rx_marker = bus.sw_data_i[BUS_SIZE-1];
    assign rx_dest   = bus.sw_data_i[BUS_SIZE-2:DATA_SIZE];
    assign rx_good   = rx_marker && (rx_dest == ADDR_SIZE'(ADDR));
    assign rx_accept = bus.sw_wr_ready_in && rx_wr_rdy;
    assign rx_push   = rx_accept && rx_good;
    assign rx_drop   = rx_accept && !rx_good;

    fifo2 #(.WIDTH(DATA_SIZE)) u_rx_fifo (
        .clk    (clk),
        .rst    (a_rst),
        .wr_vld (bus.sw_wr_ready_in && rx_good),
        .wr_rdy (rx_wr_rdy),
        .wr_dat (bus.sw_data_i[DATA_SIZE-1:0]),
        .rd_vld (bus.core_rx_valid),
        .rd_rdy (bus.core_rx_ready),
        .rd_dat (bus.core_rx_data)
    );

    assign bus.sw_r_ready_out = rx_wr_rdy;

    // Saturating statistics counters: hold at all-ones instead of wrapping.
    always_comb begin
        tx_count_d  = tx_count_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        if (tx_fire && (tx_count_q != CNT_MAX)) begin
            tx_count_d = tx_count_q + CNT_ONE;
        end
        if (rx_push && (rx_count_q != CNT_MAX)) begin
            rx_count_d = rx_count_q + CNT_ONE;
        end
        if (rx_drop && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_node_interface.sv
// Directed bench for node_interface: vector table for TX/RX flow, plus reset and saturation sequences.
module tb_node_interface;
    logic        clk;
    logic        a_rst;
    logic [15:0] tx_count, rx_count, err_count;
    logic [1:0]  tx_count_s, rx_count_s, err_count_s;

    int checks;
    int errors;

    node_interface_if #(.DATA_SIZE(32), .ADDR_SIZE(4)) bus ();
    node_interface_if #(.DATA_SIZE(32), .ADDR_SIZE(4)) bus_s ();

    node_interface #(.DATA_SIZE(32), .ADDR_SIZE(4), .ADDR(0), .CNT_SIZE(16)) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .bus       (bus),
        .tx_count  (tx_count),
        .rx_count  (rx_count),
        .err_count (err_count)
    );

    // Small-counter instance at a non-zero address for saturation and address-match checks.
    node_interface #(.DATA_SIZE(32), .ADDR_SIZE(4), .ADDR(3), .CNT_SIZE(2)) dut_s (
        .clk       (clk),
        .a_rst     (a_rst),
        .bus       (bus_s),
        .tx_count  (tx_count_s),
        .rx_count  (rx_count_s),
        .err_count (err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [3:0]  td;
        logic [31:0] tdat;
        logic        srr;
        logic        swi;
        logic [36:0] sdi;
        logic        crr;
        logic        e_tr;
        logic        e_swo;
        logic [36:0] e_sdo;
        logic        e_sro;
        logic        e_rv;
        logic [31:0] e_rd;
        logic [15:0] e_tc;
        logic [15:0] e_rc;
        logic [15:0] e_ec;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_rst  = 1'b1;
        bus.core_tx_valid   = 1'b0;
        bus.core_tx_dest    = '0;
        bus.core_tx_data    = '0;
        bus.core_rx_ready   = 1'b0;
        bus.sw_r_ready_in   = 1'b0;
        bus.sw_wr_ready_in  = 1'b0;
        bus.sw_data_i       = '0;
        bus_s.core_tx_valid  = 1'b0;
        bus_s.core_tx_dest   = '0;
        bus_s.core_tx_data   = '0;
        bus_s.core_rx_ready  = 1'b0;
        bus_s.sw_r_ready_in  = 1'b0;
        bus_s.sw_wr_ready_in = 1'b0;
        bus_s.sw_data_i      = '0;

        //           tv    td     tdat          srr   swi   sdi              crr  | tr   swo   sdo              sro   rv    rd             tc     rc     ec
        vecs[0]  = '{1'b1, 4'h5, 32'hA5A50001, 1'b1, 1'b0, 37'h0,           1'b0, 1'b1, 1'b1, 37'h15A5A50001, 1'b1, 1'b0, 32'h0,        16'd0, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 37'h0,           1'b0, 1'b1, 1'b0, 37'h0,          1'b1, 1'b0, 32'h0,        16'd1, 16'd0, 16'd0};
        vecs[2]  = '{1'b1, 4'h2, 32'h11111111, 1'b0, 1'b0, 37'h0,           1'b0, 1'b1, 1'b1, 37'h1211111111, 1'b1, 1'b0, 32'h0,        16'd1, 16'd0, 16'd0};
        vecs[3]  = '{1'b1, 4'h4, 32'h22222222, 1'b0, 1'b0, 37'h0,           1'b0, 1'b0, 1'b1, 37'h1211111111, 1'b1, 1'b0, 32'h0,        16'd1, 16'd0, 16'd0};
        vecs[4]  = '{1'b1, 4'hF, 32'h33333333, 1'b0, 1'b0, 37'h0,           1'b0, 1'b0, 1'b1, 37'h1211111111, 1'b1, 1'b0, 32'h0,        16'd1, 16'd0, 16'd0};
        vecs[5]  = '{1'b1, 4'hF, 32'h33333333, 1'b1, 1'b0, 37'h0,           1'b0, 1'b1, 1'b1, 37'h1422222222, 1'b1, 1'b0, 32'h0,        16'd2, 16'd0, 16'd0};
        vecs[6]  = '{1'b1, 4'hF, 32'h33333333, 1'b1, 1'b0, 37'h0,           1'b0, 1'b1, 1'b1, 37'h1F33333333, 1'b1, 1'b0, 32'h0,        16'd3, 16'd0, 16'd0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 37'h0,           1'b0, 1'b1, 1'b0, 37'h0,          1'b1, 1'b0, 32'h0,        16'd4, 16'd0, 16'd0};
        vecs[8]  = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h1000001234,  1'b0, 1'b1, 1'b0, 37'h0,          1'b1, 1'b1, 32'h00001234, 16'd4, 16'd1, 16'd0};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h1300005678,  1'b0, 1'b1, 1'b0, 37'h0,          1'b1, 1'b1, 32'h00001234, 16'd4, 16'd1, 16'd1};
        vecs[10] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 37'h0,           1'b1, 1'b1, 1'b0, 37'h0,          1'b1, 1'b0, 32'h0,        16'd4, 16'd1, 16'd1};
        vecs[11] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h10AAAA0001,  1'b0, 1'b1, 1'b0, 37'h0,          1'b1, 1'b1, 32'hAAAA0001, 16'd4, 16'd2, 16'd1};
        vecs[12] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h10BBBB0002,  1'b0, 1'b1, 1'b0, 37'h0,          1'b0, 1'b1, 32'hAAAA0001, 16'd4, 16'd3, 16'd1};
        vecs[13] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h10CCCC0003,  1'b0, 1'b1, 1'b0, 37'h0,          1'b0, 1'b1, 32'hAAAA0001, 16'd4, 16'd3, 16'd1};
        vecs[14] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h10CCCC0003,  1'b1, 1'b1, 1'b0, 37'h0,          1'b1, 1'b1, 32'hBBBB0002, 16'd4, 16'd3, 16'd1};
        vecs[15] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h10CCCC0003,  1'b1, 1'b1, 1'b0, 37'h0,          1'b1, 1'b1, 32'hCCCC0003, 16'd4, 16'd4, 16'd1};
        vecs[16] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 37'h0,           1'b1, 1'b1, 1'b0, 37'h0,          1'b1, 1'b0, 32'h0,        16'd4, 16'd4, 16'd1};
        vecs[17] = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 37'h0000009999,  1'b0, 1'b1, 1'b0, 37'h0,          1'b1, 1'b0, 32'h0,        16'd4, 16'd4, 16'd2};

        // Reset state while reset is held.
        #12;
        chk("rst tx_ready",  64'(bus.core_tx_ready),   64'd1);
        chk("rst sw_wr_out", 64'(bus.sw_wr_ready_out), 64'd0);
        chk("rst sw_r_out",  64'(bus.sw_r_ready_out),  64'd1);
        chk("rst rx_valid",  64'(bus.core_rx_valid),   64'd0);
        chk("rst sw_data_o", 64'(bus.sw_data_o),       64'd0);
        chk("rst rx_data",   64'(bus.core_rx_data),    64'd0);
        chk("rst tx_count",  64'(tx_count),            64'd0);
        chk("rst rx_count",  64'(rx_count),            64'd0);
        chk("rst err_count", 64'(err_count),           64'd0);
        a_rst = 1'b0;
        step();

        // Table-driven TX/RX flow.
        for (int i = 0; i < 18; i++) begin
            bus.core_tx_valid  = vecs[i].tv;
            bus.core_tx_dest   = vecs[i].td;
            bus.core_tx_data   = vecs[i].tdat;
            bus.sw_r_ready_in  = vecs[i].srr;
            bus.sw_wr_ready_in = vecs[i].swi;
            bus.sw_data_i      = vecs[i].sdi;
            bus.core_rx_ready  = vecs[i].crr;
            step();
            chk($sformatf("row%0d tx_ready", i),  64'(bus.core_tx_ready),   64'(vecs[i].e_tr));
            chk($sformatf("row%0d sw_wr_out", i), 64'(bus.sw_wr_ready_out), 64'(vecs[i].e_swo));
            chk($sformatf("row%0d sw_r_out", i),  64'(bus.sw_r_ready_out),  64'(vecs[i].e_sro));
            chk($sformatf("row%0d rx_valid", i),  64'(bus.core_rx_valid),   64'(vecs[i].e_rv));
            chk($sformatf("row%0d tx_count", i),  64'(tx_count),            64'(vecs[i].e_tc));
            chk($sformatf("row%0d rx_count", i),  64'(rx_count),            64'(vecs[i].e_rc));
            chk($sformatf("row%0d err_count", i), 64'(err_count),           64'(vecs[i].e_ec));
            if (vecs[i].e_swo)
                chk($sformatf("row%0d sw_data_o", i), 64'(bus.sw_data_o), 64'(vecs[i].e_sdo));
            if (vecs[i].e_rv)
                chk($sformatf("row%0d rx_data", i), 64'(bus.core_rx_data), 64'(vecs[i].e_rd));
        end

        // Fill both FIFOs, then assert reset between clock edges.
        bus.core_tx_valid  = 1'b1;
        bus.core_tx_dest   = 4'h7;
        bus.core_tx_data   = 32'hDEADBEEF;
        bus.sw_r_ready_in  = 1'b0;
        bus.sw_wr_ready_in = 1'b1;
        bus.sw_data_i      = 37'h1012345678;
        bus.core_rx_ready  = 1'b0;
        step();
        step();
        chk("full tx_ready", 64'(bus.core_tx_ready),  64'd0);
        chk("full sw_r_out", 64'(bus.sw_r_ready_out), 64'd0);
        #3;
        a_rst = 1'b1;
        #1;
        chk("async tx_ready",  64'(bus.core_tx_ready),   64'd1);
        chk("async sw_wr_out", 64'(bus.sw_wr_ready_out), 64'd0);
        chk("async sw_r_out",  64'(bus.sw_r_ready_out),  64'd1);
        chk("async rx_valid",  64'(bus.core_rx_valid),   64'd0);
        chk("async sw_data_o", 64'(bus.sw_data_o),       64'd0);
        chk("async rx_data",   64'(bus.core_rx_data),    64'd0);
        chk("async tx_count",  64'(tx_count),            64'd0);
        chk("async err_count", 64'(err_count),           64'd0);
        bus.core_tx_valid  = 1'b0;
        bus.sw_wr_ready_in = 1'b0;
        step();
        step();
        a_rst = 1'b0;
        bus.sw_r_ready_in = 1'b1;
        bus.core_rx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst%0d sw_wr_out", k), 64'(bus.sw_wr_ready_out), 64'd0);
            chk($sformatf("post_rst%0d rx_valid", k),  64'(bus.core_rx_valid),   64'd0);
            chk($sformatf("post_rst%0d tx_count", k),  64'(tx_count),            64'd0);
            chk($sformatf("post_rst%0d rx_count", k),  64'(rx_count),            64'd0);
        end

        // Saturation on the 2-bit-counter instance: 5 flits sent, count holds at 3.
        bus_s.sw_r_ready_in = 1'b1;
        bus_s.core_tx_valid = 1'b1;
        bus_s.core_tx_dest  = 4'h1;
        bus_s.core_tx_data  = 32'h0000CAFE;
        step();
        step();
        step();
        chk("sat tx_count mid", 64'(tx_count_s), 64'd2);
        step();
        step();
        bus_s.core_tx_valid = 1'b0;
        step();
        step();
        chk("sat tx_count",   64'(tx_count_s),            64'd3);
        chk("sat sw_wr_out",  64'(bus_s.sw_wr_ready_out), 64'd0);

        // Misrouted flits saturate err_count; a flit for address 3 is delivered.
        bus_s.core_rx_ready  = 1'b1;
        bus_s.sw_wr_ready_in = 1'b1;
        bus_s.sw_data_i      = 37'h1000000BAD;
        for (int k = 0; k < 4; k++) step();
        chk("sat err_count", 64'(err_count_s), 64'd3);
        chk("sat rx_valid0", 64'(bus_s.core_rx_valid), 64'd0);
        bus_s.core_rx_ready = 1'b0;
        bus_s.sw_data_i     = 37'h130000D00D;
        step();
        bus_s.sw_wr_ready_in = 1'b0;
        chk("addr3 rx_valid", 64'(bus_s.core_rx_valid), 64'd1);
        chk("addr3 rx_data",  64'(bus_s.core_rx_data),  64'h0000D00D);
        chk("addr3 rx_count", 64'(rx_count_s),          64'd1);
        chk("addr3 err_count", 64'(err_count_s),        64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
